// File: rtl/uart_loader.sv
// uart_loader: receives a framed program image from a byte-wide UART
// receiver, writes it word by word into RAM, verifies an 8-bit additive
// checksum and then releases the CPU.
//
// Frame: 0xA5, N_lo, N_hi, 4*N payload bytes (little-endian words),
//        checksum byte = sum of payload bytes mod 256.
//
// Ports
//   clk          : single clock, rising edge
//   i_reset      : synchronous, active-high reset
//   rx_valid     : one-cycle byte strobe from the UART receiver
//   rx_data      : received byte, valid with rx_valid
//   mem_wr_en    : one-cycle RAM write strobe
//   mem_wr_addr  : RAM byte address (word aligned), held between writes
//   mem_wr_data  : RAM write word, held between writes
//   cpu_running  : program loaded and checksum good, CPU released
//   load_error   : sticky, last load attempt failed
module uart_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 1024,
  parameter int          TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        cpu_running,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RUN
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_csum;
  logic [23:0] r_buf;        // lanes 0..2; lane 3 comes straight from rx_data
  logic [31:0] r_tmo;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_run;
  logic        r_err;

  state_t      w_next;
  logic        w_start;
  logic        w_fail;
  logic        w_pass;
  logic        w_active;
  logic        w_tmo;
  logic        w_word_done;
  logic        w_last_word;
  logic [15:0] w_len_new;

  assign w_len_new   = {rx_data, r_len[7:0]};
  assign w_active    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_tmo       = w_active && !rx_valid && (r_tmo == TMO_LAST);
  assign w_word_done = (r_state == S_DATA) && rx_valid && (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_idx == (r_len - 16'd1));

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_fail  = 1'b0;
    w_pass  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == 8'hA5)) begin
          w_next  = S_LEN_LO;
          w_start = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          w_next = S_LEN_HI;
        end else if (w_tmo) begin
          w_next = S_IDLE;
          w_fail = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if ((w_len_new == 16'd0) || ({1'b0, w_len_new} > MAX_N)) begin
            w_next = S_IDLE;
            w_fail = 1'b1;
          end else begin
            w_next = S_DATA;
          end
        end else if (w_tmo) begin
          w_next = S_IDLE;
          w_fail = 1'b1;
        end
      end
      S_DATA: begin
        if (w_word_done && w_last_word) begin
          w_next = S_CSUM;
        end else if (w_tmo) begin
          w_next = S_IDLE;
          w_fail = 1'b1;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == r_csum) begin
            w_next = S_RUN;
            w_pass = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_fail = 1'b1;
          end
        end else if (w_tmo) begin
          w_next = S_IDLE;
          w_fail = 1'b1;
        end
      end
      S_RUN:   w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_buf      <= '0;
      r_tmo      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= 1'b0;

      if (w_active && !rx_valid) r_tmo <= r_tmo + 32'd1;
      else                       r_tmo <= '0;

      if (w_start) begin
        r_err      <= 1'b0;
        r_csum     <= '0;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
      end
      if (w_fail) r_err <= 1'b1;
      if (w_pass) r_run <= 1'b1;

      if (rx_valid && (r_state == S_LEN_LO)) r_len[7:0]  <= rx_data;
      if (rx_valid && (r_state == S_LEN_HI)) r_len[15:8] <= rx_data;

      if (rx_valid && (r_state == S_DATA)) begin
        r_csum     <= r_csum + rx_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_buf[7:0]   <= rx_data;
          2'd1:    r_buf[15:8]  <= rx_data;
          2'd2:    r_buf[23:16] <= rx_data;
          default: ;
        endcase
        if (w_word_done) begin
          r_wr_en    <= 1'b1;
          r_wr_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
          r_wr_data  <= {rx_data, r_buf};
          r_word_idx <= r_word_idx + 16'd1;
        end
      end
    end
  end

  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign cpu_running = r_run;
  assign load_error  = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed bench for uart_loader. Expected RAM writes are
// queued as frames are sent and popped by a write monitor that also checks
// the write lands exactly one cycle after the word's last byte.
module tb_uart_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        cpu_running;
  logic        load_error;

  uart_loader #(
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (1024),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .cpu_running(cpu_running),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  neg_cnt  = 0;
  int  wr_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampling on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (mem_wr_en === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_wr_addr, e.addr);
        chk("wr_data", mem_wr_data, e.data);
        chk("wr_cycle", 32'(neg_cnt + 1), 32'(e.cyc));
      end
    end
    neg_cnt++;
  end

  // Callers are always at posedge+1 when this is entered.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = neg_cnt + 1;
    sb.push_back(e);
  endtask

  // Sends one word; the last byte's write (if expected) is queued right
  // after its sampling edge.
  task automatic send_word(input logic [31:0] w, input int idx, input bit exp_wr,
                           inout logic [7:0] csum);
    for (int b = 0; b < 4; b++) begin
      csum = csum + w[8*b +: 8];
      if (b < 3) begin
        send_byte(w[8*b +: 8], 1);
      end else begin
        send_byte(w[8*b +: 8], 0);
        if (exp_wr) push_wr(BASE + 32'(4 * idx), w);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input bit bad_csum, input bit exp_wr);
    logic [7:0] csum;
    logic [15:0] nn;
    csum = 8'h00;
    nn   = 16'(n);
    send_byte(8'hA5, 1);
    send_byte(nn[7:0], 1);
    send_byte(nn[15:8], 1);
    for (int i = 0; i < n; i++) send_word((i == 0) ? w0 : w1, i, exp_wr, csum);
    send_byte(bad_csum ? (csum + 8'd1) : csum, 1);
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    rx_valid = 1'b1;   // must be ignored while in reset
    rx_data  = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    i_reset  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    chk({tag, "_addr"}, mem_wr_addr, 32'd0);
    chk({tag, "_data"}, mem_wr_data, 32'd0);
    chk({tag, "_run"}, {31'd0, cpu_running}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_error}, 32'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] cs;
    i_reset  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk); #1;
    do_reset();
    chk_zero("reset");

    // Noise before sync, then nominal two-word load.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    chk("noise_no_wr", 32'(wr_count), 32'd0);
    send_frame(2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("nom_run", {31'd0, cpu_running}, 32'd1);
    chk("nom_err", {31'd0, load_error}, 32'd0);
    chk("nom_wr_count", 32'(wr_count), 32'd2);
    chk("nom_sb_empty", 32'(sb.size()), 32'd0);

    // RUN is terminal: a further frame produces no writes.
    w0 = wr_count;
    send_frame(1, 32'h4433_2211, 32'h0, 1'b0, 1'b0);
    chk("run_lock_wr", 32'(wr_count), 32'(w0));
    chk("run_lock_run", {31'd0, cpu_running}, 32'd1);

    do_reset();
    chk_zero("reset2");

    // Bad checksum: writes still happen, load fails, then a good frame loads.
    send_frame(2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("badcs_err", {31'd0, load_error}, 32'd1);
    chk("badcs_run", {31'd0, cpu_running}, 32'd0);
    chk("badcs_wr_count", 32'(wr_count), 32'(w0 + 2));
    send_frame(2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("retry_run", {31'd0, cpu_running}, 32'd1);
    chk("retry_err", {31'd0, load_error}, 32'd0);

    do_reset();

    // Length errors.
    w0 = wr_count;
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    chk("len0_err", {31'd0, load_error}, 32'd1);
    send_byte(8'hA5, 1);
    chk("sync_clears_err", {31'd0, load_error}, 32'd0);
    send_byte(8'h01, 1);
    send_byte(8'h04, 1);
    chk("len1025_err", {31'd0, load_error}, 32'd1);
    send_byte(8'hDE, 1);
    send_byte(8'hAD, 1);
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 1);
    chk("len_err_no_wr", 32'(wr_count), 32'(w0));

    // Timeout after two payload bytes: alive after 15 idle cycles, aborted after 16.
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 0);
    repeat (15) begin @(posedge clk); #1; end
    chk("tmo_15_alive", {31'd0, load_error}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_16_err", {31'd0, load_error}, 32'd1);
    chk("tmo_no_wr", 32'(wr_count), 32'(w0));
    chk("tmo_run", {31'd0, cpu_running}, 32'd0);
    // The expired partial word must be gone: the word here is CC DD EE FF only.
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 1);
    chk("tmo_idle_no_wr", 32'(wr_count), 32'(w0));

    // Byte coinciding with the expiry cycle keeps the load alive.
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 0);
    repeat (15) begin @(posedge clk); #1; end
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 0);
    push_wr(BASE, 32'hDDCC_BBAA);
    @(posedge clk); #1;
    cs = 8'hAA + 8'hBB + 8'hCC + 8'hDD;
    send_byte(cs, 1);
    chk("tmo_edge_run", {31'd0, cpu_running}, 32'd1);
    chk("tmo_edge_err", {31'd0, load_error}, 32'd0);
    chk("tmo_edge_wr", 32'(wr_count), 32'(w0 + 1));

    do_reset();

    // Reset in the middle of the second word.
    w0 = wr_count;
    cs = 8'h00;
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    send_word(32'h1234_5678, 0, 1'b1, cs);
    send_byte(8'hEF, 1);
    send_byte(8'hBE, 0);
    do_reset();
    chk_zero("mid_reset");
    chk("mid_reset_wr", 32'(wr_count), 32'(w0 + 1));
    send_frame(2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0, 1'b1);
    chk("fresh_run", {31'd0, cpu_running}, 32'd1);
    chk("fresh_wr", 32'(wr_count), 32'(w0 + 3));
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
